// File: rtl/countdown_timer.sv
// Loadable N-bit down-counter with start/stop/pause control, busy/paused status and a done pulse at expiry.
// Build option: define COUNTDOWN_AUTORELOAD_EN to reload and keep running on expiry (periodic done).
module countdown_timer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         paused
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [N-1:0] ONE = 1;

  state_t       state, state_nx;
  logic [N-1:0] q_nx;
  logic [N-1:0] reload, reload_nx;
  logic         done_nx;

  function automatic logic [N-1:0] dec(input logic [N-1:0] v);
    return v - ONE;
  endfunction

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    reload_nx = reload;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          q_nx      = load_value;
          reload_nx = load_value;
        end else if (start) begin
          // Starting an already-expired count reports expiry without running.
          if (q != '0) state_nx = RUN;
          else         done_nx  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (pause) begin
          state_nx = HOLD;
        end else if (q > ONE) begin
          q_nx = dec(q);
        end else begin
          done_nx = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          q_nx = reload;
`else
          q_nx     = '0;
          state_nx = IDLE;
`endif
        end
      end
      HOLD: begin
        // Resuming spends one cycle in RUN before the next decrement.
        if (stop)        state_nx = IDLE;
        else if (!pause) state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      paused <= 1'b0;
    end else begin
      state  <= state_nx;
      q      <= q_nx;
      reload <= reload_nx;
      done   <= done_nx;
      busy   <= (state_nx != IDLE);
      paused <= (state_nx == HOLD);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_countdown_timer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [N-1:0] q;
  logic         busy, done, paused;

  typedef struct {
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         paused;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  countdown_timer #(.N(N)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .pause(pause),
    .q(q), .busy(busy), .done(done), .paused(paused)
  );

  always #5 clk = ~clk;

  function automatic void compare(input exp_t e);
    total++;
    if (q !== e.q || busy !== e.busy || done !== e.done || paused !== e.paused) begin
      bad++;
      $display("FAIL %s: got q=%0d busy=%b done=%b paused=%b, want q=%0d busy=%b done=%b paused=%b",
               e.tag, q, busy, done, paused, e.q, e.busy, e.done, e.paused);
    end
  endfunction

  // Monitor: one expectation per rising edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) compare(exp_q.pop_front());
  end

  task automatic step(input logic ld, input logic [N-1:0] lv, input logic st,
                      input logic sp, input logic pa,
                      input logic [N-1:0] eq, input logic eb, input logic ed,
                      input logic ep, input string tag);
    exp_t e;
    @(negedge clk);
    load = ld; load_value = lv; start = st; stop = sp; pause = pa;
    e.q = eq; e.busy = eb; e.done = ed; e.paused = ep; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [N-1:0] eq, input logic eb, input logic ed, input string tag);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, eq, eb, ed, 1'b0, tag);
  endtask

  task automatic now_check(input string tag);
    exp_t e;
    e.q = '0; e.busy = 1'b0; e.done = 1'b0; e.paused = 1'b0; e.tag = tag;
    compare(e);
  endtask

  initial begin
    #1 now_check("reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Start with nothing loaded: immediate one-cycle done, never busy.
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "start_q0_done");
    idle(4'd0, 1'b0, 1'b0, "start_q0_done_drop");

    // Plain countdown from 5.
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, "load5");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, "start5");
    for (int k = 4; k >= 1; k--) idle(N'(k), 1'b1, 1'b0, "count5");
    idle(4'd0, 1'b0, 1'b1, "expire5");
    idle(4'd0, 1'b0, 1'b0, "done5_one_cycle");

    // Pause for 4 cycles at q=3, then a no-decrement resume cycle.
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0, "load6");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, "start6");
    for (int k = 5; k >= 3; k--) idle(N'(k), 1'b1, 1'b0, "count6");
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, "hold3");
    idle(4'd3, 1'b1, 1'b0, "resume3");
    idle(4'd2, 1'b1, 1'b0, "count6_after");
    idle(4'd1, 1'b1, 1'b0, "count6_after");
    idle(4'd0, 1'b0, 1'b1, "expire6");

    // Stop at 4, then simultaneous load+start loads only.
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, "load9");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, "start9");
    for (int k = 8; k >= 4; k--) idle(N'(k), 1'b1, 1'b0, "count9");
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, "stop_at4");
    idle(4'd4, 1'b0, 1'b0, "stopped_no_done");
    step(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, "load_beats_start");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, "start2");
    idle(4'd1, 1'b1, 1'b0, "count2");
    idle(4'd0, 1'b0, 1'b1, "expire2");

    // Full range; load/start ignored while running.
    step(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, "load15");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, "start15");
    for (int k = 14; k >= 7; k--) idle(N'(k), 1'b1, 1'b0, "count15");
    step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, "load_ignored_run");
    for (int k = 5; k >= 1; k--) idle(N'(k), 1'b1, 1'b0, "count15_tail");
    idle(4'd0, 1'b0, 1'b1, "expire15");
    idle(4'd0, 1'b0, 1'b0, "done15_drop");

    // Asynchronous reset mid-count at q=10.
    step(1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, "reload15");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b0, "restart15");
    for (int k = 14; k >= 10; k--) idle(N'(k), 1'b1, 1'b0, "count_to10");
    @(negedge clk);
    #1 reset = 1'b0;
    #1 now_check("async_reset_mid");
    @(negedge clk) reset = 1'b1;

    // Expiry from a load of 3: periodic in the autoreload build, one-shot otherwise.
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "load3");
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, "start3");
`ifdef COUNTDOWN_AUTORELOAD_EN
    for (int k = 1; k <= 12; k++)
      idle((k % 3 == 0) ? 4'd3 : N'(3 - (k % 3)), 1'b1, (k % 3 == 0), "autoreload");
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, "autoreload_stop");
`else
    idle(4'd2, 1'b1, 1'b0, "oneshot3");
    idle(4'd1, 1'b1, 1'b0, "oneshot3");
    idle(4'd0, 1'b0, 1'b1, "oneshot3_expire");
    idle(4'd0, 1'b0, 1'b0, "oneshot3_stays");
`endif

    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- N-bit loadable down-counter with a start/stop/pause handshake, busy status and a one-cycle done pulse on reaching zero.
- Companion to the free-running up-counter: the up-counter measures elapsed cycles, this block expires after a programmed cycle count.
- Used by control logic for timeouts and fixed delays. Single clock domain.

Parameters:
N, 4, counter width in bits; load_value range 0..2^N-1

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load  input  1  load load_value into counter; accepted only in IDLE
load_value  input  N  count to load
start  input  1  begin countdown; accepted only in IDLE
stop  input  1  abort countdown; accepted in RUN/HOLD
pause  input  1  level; freezes countdown while high
q  output  N  current count, registered
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse, expiry
paused  output  1  high in HOLD

Behaviour:
- Reset (reset=0, asynchronous, immediate): state=IDLE, q=0, reload register=0, busy=0, done=0, paused=0. Reset deasserts synchronously in effect; first active edge follows.
- States: IDLE, RUN, HOLD. All outputs registered. busy = (RUN|HOLD), paused = HOLD.
- done defaults to 0 every edge unless set below. Never high more than one consecutive cycle without autoreload.
- IDLE:
  - load=1: q<=load_value, reload<=load_value. start is ignored on the same edge (load has priority).
  - start=1, load=0, q!=0: go to RUN. q is unchanged on this edge.
  - start=1, load=0, q==0: done<=1, stay IDLE.
  - stop and pause are ignored.
- RUN, priority stop > pause > count:
  - stop=1: go to IDLE, q held, no done.
  - pause=1: go to HOLD, q held.
  - q>1: q<=q-1.
  - q==1: q<=0, done<=1, go to IDLE.
- HOLD:
  - stop=1: go to IDLE, q held, no done.
  - pause=0: go to RUN, q held. Resume costs one cycle with no decrement.
  - Otherwise hold.
- load and start are ignored in RUN and HOLD.
- Latency: with load L≥1 and start sampled at edge E and no pause, q=L-k after edge E+k. q=0, done=1, busy=0 after edge E+L. done is high for exactly the cycle following edge E+L.
- Arithmetic: decrement is modulo 2^N but is never applied at q==0, so there is no underflow wrap. L=2^N-1 counts the full range.
- Reset mid-operation: immediate return to reset values regardless of state. A pending done is lost.

Optional Feature:
COUNTDOWN_AUTORELOAD_EN
- Defined: in RUN at q==1, q<=reload, done<=1, and the state stays RUN. This gives a periodic done pulse every L counting cycles until stop. pause and stop behave as above. Reaching zero never drops busy.
- Undefined: one-shot behaviour as in Behaviour.
- The IDLE start-with-q==0 rule applies in both builds.

Test Plan:
1. N=4; hold reset=0 for 2 cycles then release -> q=0, busy=0, done=0. Start with no load -> done pulses exactly 1 cycle, busy stays 0.
2. load 4'd5, then start (1 cycle) -> q=5,4,3,2,1,0 on successive edges after start. done=1 for exactly the cycle where q first reads 0. busy=1 for 5 cycles then 0.
3. load 4'd6, start; raise pause when q=3 for 4 cycles -> q holds 3, paused=1. After pause falls, one further cycle at 3, then 2,1,0. done occurs 5 cycles later than the no-pause case.
4. load 4'd9, start; stop when q=4 -> q stays 4, busy=0, done never asserts. Assert load 4'd2 and start simultaneously -> q=2, still IDLE; next start counts 2,1,0 with done.
5. load 4'd15, start; while q=7, assert load 4'd3 and start -> both ignored, countdown continues to 0. Then drive reset=0 mid-count in a second run at q=10 -> q=0, busy=0 immediately, without waiting for a clock edge.
6. With COUNTDOWN_AUTORELOAD_EN: load 4'd3, start, run 12 cycles -> q sequence 3,2,1,3,2,1,... with done high every third cycle and busy constantly 1. Then stop -> IDLE, q held.
